// File: rtl/pcm_to_pdm.sv
// PCM to PDM converter: FIFO-buffered signed samples driving a first-order sigma-delta modulator.
// Latency: a pushed sample takes effect on the first fall event after the next frame boundary.
// Backpressure: pcm_ready is low while the FIFO is full; pcm_valid is ignored while pcm_ready is low.
module pcm_to_pdm #(
  parameter int BIT_WIDTH          = 8,
  parameter int PDM_CLK_DEC_FACTOR = 12,
  parameter int DEC_FACTOR         = 128,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BIT_WIDTH-1:0]          pcm_in,
  input  logic                          pcm_valid,
  output logic                          pcm_ready,
  output logic                          pdm_clk,
  output logic                          pdm,
  output logic                          frame_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          clr_underrun
);

  localparam int DIV_W = (PDM_CLK_DEC_FACTOR > 1) ? $clog2(PDM_CLK_DEC_FACTOR) : 1;
  localparam int CNT_W = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ACC_W = BIT_WIDTH + 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PDM_CLK_DEC_FACTOR - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_FACTOR - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  // Feedback magnitude is half the sample range: +/- 2^(BIT_WIDTH-1).
  localparam logic [ACC_W-1:0] FB_POS   = {3'b001, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [ACC_W-1:0] FB_NEG   = ~FB_POS + ACC_W'(1);

  logic [DIV_W-1:0]     r_div;
  logic                 r_pdm_clk;
  logic                 r_pdm;
  logic [ACC_W-1:0]     r_acc;
  logic [BIT_WIDTH-1:0] r_cur;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [BIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_underrun;

  logic                 w_div_tc;
  logic                 w_fall;
  logic                 w_boundary;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_y;
  logic [ACC_W-1:0]     w_cur_ext;
  logic [ACC_W-1:0]     w_acc_nxt;

  // Modulator and frame state only move when pdm_clk falls, so pdm is stable
  // for half a pdm_clk period on either side of the receiver's rising edge.
  assign w_div_tc   = (r_div == DIV_LAST);
  assign w_fall     = w_div_tc & r_pdm_clk;
  assign w_boundary = w_fall & (r_bit_cnt == CNT_LAST);
  assign pcm_ready  = (r_level < LVL_FULL);
  assign w_push     = pcm_valid & pcm_ready;
  assign w_pop      = w_boundary & (r_level != '0);

  // acc is signed; its MSB is the sign, so y = (acc >= 0) is the inverted MSB.
  assign w_y        = ~r_acc[ACC_W-1];
  assign w_cur_ext  = {{2{r_cur[BIT_WIDTH-1]}}, r_cur};
  assign w_acc_nxt  = r_acc + w_cur_ext - (w_y ? FB_POS : FB_NEG);

  assign pdm_clk      = r_pdm_clk;
  assign pdm          = r_pdm;
  assign frame_strobe = w_boundary;
  assign fifo_level   = r_level;
  assign underrun     = r_underrun;

  // Divide clk down to pdm_clk: toggle every PDM_CLK_DEC_FACTOR cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_pdm_clk <= 1'b0;
    end else if (w_div_tc) begin
      r_div     <= '0;
      r_pdm_clk <= ~r_pdm_clk;
    end else begin
      r_div     <= r_div + DIV_W'(1);
    end
  end

  // Sigma-delta step and frame bit counter on each fall event; the bit emitted
  // at a boundary still uses the outgoing sample, the new one applies next fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pdm     <= 1'b0;
      r_acc     <= '0;
      r_bit_cnt <= '0;
      r_cur     <= '0;
    end else begin
      if (w_fall) begin
        r_pdm     <= w_y;
        r_acc     <= w_acc_nxt;
        r_bit_cnt <= (r_bit_cnt == CNT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_cur <= r_mem[r_rd_ptr];
      end
    end
  end

  // FIFO storage needs no reset; emptiness is defined by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pcm_in;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

  // Sticky underrun: a boundary with nothing to pop sets it and beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if (w_boundary && (r_level == '0)) begin
      r_underrun <= 1'b1;
    end else if (clr_underrun) begin
      r_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcm_to_pdm.sv
module tb_pcm_to_pdm;

  localparam int PCF      = 12;
  localparam int DEC      = 128;
  localparam int DEPTH    = 4;
  localparam int FALL_PER = 2 * PCF;
  localparam int FRAME    = FALL_PER * DEC;
  localparam int HALF     = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pcm_in = 8'd0;
  logic       pcm_valid = 1'b0;
  logic       pcm_ready;
  logic       pdm_clk;
  logic       pdm;
  logic       frame_strobe;
  logic [2:0] fifo_level;
  logic       underrun;
  logic       clr_underrun = 1'b0;

  pcm_to_pdm #(
    .BIT_WIDTH(8), .PDM_CLK_DEC_FACTOR(PCF), .DEC_FACTOR(DEC), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .pdm_clk(pdm_clk), .pdm(pdm),
    .frame_strobe(frame_strobe), .fifo_level(fifo_level),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  // Reference model state (time measured in clk edges since reset release).
  int k;
  int m_q[$];
  int m_cur;
  int m_acc;
  bit m_pdm;
  bit m_underrun;
  bit m_strobe;
  bit last_fall;
  int fall_idx;
  int dut_ones;
  int mdl_ones;
  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    k = 0; m_q.delete(); m_cur = 0; m_acc = 0; m_pdm = 1'b0;
    m_underrun = 1'b0; m_strobe = 1'b0; fall_idx = 0; last_fall = 1'b0;
  endtask

  // Advance one clk: apply the spec rules to the model, then clock the DUT.
  task automatic step();
    bit fall, bnd, push;
    fall = ((k + 1) % FALL_PER) == 0;
    bnd  = fall && ((((k + 1) / FALL_PER) % DEC) == 0);
    push = pcm_valid && (m_q.size() < DEPTH);
    if (fall) begin
      m_pdm = (m_acc >= 0);
      m_acc = m_acc + m_cur - (m_pdm ? HALF : -HALF);
    end
    if (clr_underrun) m_underrun = 1'b0;
    if (bnd) begin
      if (m_q.size() > 0) m_cur = m_q.pop_front();
      else m_underrun = 1'b1;
    end
    if (push) m_q.push_back(int'($signed(pcm_in)));
    @(posedge clk); #1;
    k++;
    last_fall = fall;
    if (fall) begin
      fall_idx++;
      if (pdm === 1'b1) dut_ones++;
      if (m_pdm) mdl_ones++;
    end
    m_strobe = (((k + 1) % FALL_PER) == 0) && ((((k + 1) / FALL_PER) % DEC) == 0);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_boundary();
    run_cycles(FRAME - (k % FRAME));
  endtask

  task automatic push_sample(input int v);
    pcm_in = 8'(v);
    pcm_valid = 1'b1;
    step();
    pcm_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pdm_clk !== 1'b0) begin errors++; $display("FAIL rst_pdm_clk got %b want 0", pdm_clk); end
    checks++; if (pdm !== 1'b0) begin errors++; $display("FAIL rst_pdm got %b want 0", pdm); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", pcm_ready); end
    checks++; if (frame_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b want 0", frame_strobe); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b want 0", underrun); end
    rst = 1'b0;
    model_reset();
  endtask

  // One frame from reset with an empty FIFO: clock period, 1,0,1,0 pattern, first strobe.
  task automatic test_idle_frame();
    int  strobe_k;
    logic exp_v;
    strobe_k = -1;
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (frame_strobe !== m_strobe) begin errors++; $display("FAIL idle_strobe k=%0d got %b want %b", k, frame_strobe, m_strobe); end
      if (frame_strobe === 1'b1 && strobe_k < 0) strobe_k = k;
      step();
      exp_v = ((k / PCF) % 2) == 1;
      checks++;
      if (pdm_clk !== exp_v) begin errors++; $display("FAIL idle_pdm_clk k=%0d got %b want %b", k, pdm_clk, exp_v); end
      if (last_fall) begin
        exp_v = (fall_idx % 2) == 1;
        checks++;
        if (pdm !== exp_v) begin errors++; $display("FAIL idle_pdm bit=%0d got %b want %b", fall_idx, pdm, exp_v); end
      end
    end
    checks++; if (strobe_k != FRAME - 1) begin errors++; $display("FAIL idle_first_strobe got %0d want %0d", strobe_k, FRAME - 1); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL idle_underrun got %b want 1", underrun); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL idle_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_underrun_clear();
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL clr_underrun got %b want 0", underrun); end
  endtask

  // Full-scale positive sample; also clear-vs-set collision at an empty boundary.
  task automatic test_full_scale();
    run_cycles($urandom_range(50, 2000));
    push_sample(127);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL fs_level_push got %0d want 1", fifo_level); end
    run_to_boundary();
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL fs_level_pop got %0d want 0", fifo_level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL fs_underrun got %b want 0", underrun); end
    dut_ones = 0; mdl_ones = 0;
    run_cycles(FRAME - 1);
    checks++; if (frame_strobe !== 1'b1) begin errors++; $display("FAIL fs_strobe got %b want 1", frame_strobe); end
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", underrun); end
    checks++; if (dut_ones < 127 || dut_ones > 128) begin errors++; $display("FAIL fs_ones_range got %0d want 127..128", dut_ones); end
    checks++; if (dut_ones != mdl_ones) begin errors++; $display("FAIL fs_ones_model got %0d want %0d", dut_ones, mdl_ones); end
  endtask

  task automatic test_min_mid();
    run_cycles($urandom_range(50, 2000));
    push_sample(-128);
    run_to_boundary();
    dut_ones = 0; mdl_ones = 0;
    run_cycles($urandom_range(50, 2000));
    push_sample(0);
    run_to_boundary();
    checks++; if (dut_ones > 1) begin errors++; $display("FAIL min_ones_range got %0d want 0..1", dut_ones); end
    checks++; if (dut_ones != mdl_ones) begin errors++; $display("FAIL min_ones_model got %0d want %0d", dut_ones, mdl_ones); end
    dut_ones = 0; mdl_ones = 0;
    run_to_boundary();
    checks++; if (dut_ones < 63 || dut_ones > 65) begin errors++; $display("FAIL mid_ones_range got %0d want 63..65", dut_ones); end
    checks++; if (dut_ones != mdl_ones) begin errors++; $display("FAIL mid_ones_model got %0d want %0d", dut_ones, mdl_ones); end
  endtask

  // Five back-to-back pushes into a 4-deep FIFO; pop order checked by per-frame density.
  task automatic test_fifo_full();
    int s[5];
    int exp_lvl;
    int diff;
    for (int i = 0; i < 4; i++) s[i] = -110 + 55 * i + int'($urandom_range(0, 10));
    s[4] = int'($urandom_range(100, 127));
    pcm_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pcm_in = s[i][7:0];
      step();
      exp_lvl = (i < 3) ? i + 1 : 4;
      checks++; if (pcm_ready !== (i < 3)) begin errors++; $display("FAIL full_ready push=%0d got %b want %b", i, pcm_ready, (i < 3)); end
      checks++; if (fifo_level !== 3'(exp_lvl)) begin errors++; $display("FAIL full_level push=%0d got %0d want %0d", i, fifo_level, exp_lvl); end
    end
    pcm_valid = 1'b0;
    run_to_boundary();
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL full_level_pop0 got %0d want 3", fifo_level); end
    for (int i = 0; i < 4; i++) begin
      dut_ones = 0; mdl_ones = 0;
      run_to_boundary();
      exp_lvl = (i < 3) ? 2 - i : 0;
      diff = 2 * dut_ones - (s[i] + HALF);
      checks++; if (dut_ones != mdl_ones) begin errors++; $display("FAIL order_ones frame=%0d got %0d want %0d", i, dut_ones, mdl_ones); end
      checks++; if (diff < -4 || diff > 4) begin errors++; $display("FAIL order_density frame=%0d got %0d want about %0d", i, dut_ones, (s[i] + HALF) / 2); end
      checks++; if (fifo_level !== 3'(exp_lvl)) begin errors++; $display("FAIL order_level frame=%0d got %0d want %0d", i, fifo_level, exp_lvl); end
    end
  endtask

  // Push landing in the boundary cycle with two entries queued.
  task automatic test_boundary_push();
    int a, b, c, diff;
    a = -128 + int'($urandom_range(0, 60));
    b = 60 + int'($urandom_range(0, 67));
    c = int'($urandom_range(0, 255)) - 128;
    run_cycles($urandom_range(20, 200));
    push_sample(a);
    push_sample(b);
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL bp_level_pre got %0d want 2", fifo_level); end
    run_cycles(FRAME - (k % FRAME) - 1);
    checks++; if (frame_strobe !== 1'b1) begin errors++; $display("FAIL bp_strobe got %b want 1", frame_strobe); end
    push_sample(c);
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL bp_level_post got %0d want 2", fifo_level); end
    dut_ones = 0; mdl_ones = 0;
    run_to_boundary();
    diff = 2 * dut_ones - (a + HALF);
    checks++; if (dut_ones != mdl_ones) begin errors++; $display("FAIL bp_ones_model got %0d want %0d", dut_ones, mdl_ones); end
    checks++; if (diff < -4 || diff > 4) begin errors++; $display("FAIL bp_old_head got %0d want about %0d", dut_ones, (a + HALF) / 2); end
  endtask

  // Reset at bit 60 of a frame with three queued samples, then a clean restart.
  task automatic test_reset_mid_frame();
    int   strobe_k;
    logic exp_v;
    push_sample(int'($urandom_range(0, 255)) - 128);
    push_sample(int'($urandom_range(0, 255)) - 128);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL rm_level_pre got %0d want 3", fifo_level); end
    run_cycles(((60 * FALL_PER) - (k % FRAME) + FRAME) % FRAME);
    rst = 1'b1;
    #1;
    checks++; if (pdm_clk !== 1'b0) begin errors++; $display("FAIL rm_pdm_clk got %b want 0", pdm_clk); end
    checks++; if (pdm !== 1'b0) begin errors++; $display("FAIL rm_pdm got %b want 0", pdm); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rm_level got %0d want 0", fifo_level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rm_underrun got %b want 0", underrun); end
    checks++; if (pcm_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", pcm_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    strobe_k = -1;
    for (int c = 0; c < FRAME; c++) begin
      if (frame_strobe === 1'b1 && strobe_k < 0) strobe_k = k;
      step();
      exp_v = ((k / PCF) % 2) == 1;
      checks++;
      if (pdm_clk !== exp_v) begin errors++; $display("FAIL rm_clk k=%0d got %b want %b", k, pdm_clk, exp_v); end
      if (last_fall && fall_idx <= 4) begin
        exp_v = (fall_idx % 2) == 1;
        checks++;
        if (pdm !== exp_v) begin errors++; $display("FAIL rm_pattern bit=%0d got %b want %b", fall_idx, pdm, exp_v); end
      end
    end
    checks++; if (strobe_k != FRAME - 1) begin errors++; $display("FAIL rm_next_strobe got %0d want %0d", strobe_k, FRAME - 1); end
  endtask

  initial begin
    test_reset();
    test_idle_frame();
    test_underrun_clear();
    test_full_scale();
    test_min_mid();
    test_fifo_full();
    test_boundary_push();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
